rng_sample_controller: RTL



---
 rtl/rng_sample_controller_pkg.sv | 16 +
 rtl/rng_sample_controller_if.sv | 10 +
 rtl/rng_sample_controller_sync.sv | 21 ++
 rtl/rng_sample_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rng_sample_controller_pkg.sv
// rng_ctrl_pkg: shared state type and default parameters for the RNG sample controller
package rng_ctrl_pkg;
  localparam int DEF_NUMBITS     = 32;
  localparam int DEF_RUN_CYCLES  = 16;
  localparam int DEF_REST_CYCLES = 4;
  localparam int DEF_REP_LIMIT   = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CAPTURE,
    S_CHECK,
    S_OUTPUT,
    S_REST,
    S_FAIL
  } state_e;
endpackage

// File: rtl/rng_sample_controller_if.sv
// rng_sample_controller_if: valid/ready word channel from the controller to its consumer
interface rng_sample_controller_if #(
  parameter int NUMBITS = rng_ctrl_pkg::DEF_NUMBITS
);
  logic [NUMBITS-1:0] rnd_data;
  logic               rnd_valid;
  logic               rnd_ready;
  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/rng_sample_controller_sync.sv
// rng_bit_synchronizer: NUMBITS-wide two-flop synchronizer for the asynchronous ring outputs
module rng_bit_synchronizer #(
  parameter int NUMBITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUMBITS-1:0] d,
  output logic [NUMBITS-1:0] q
);
  logic [NUMBITS-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/rng_sample_controller.sv
// rng_sample_controller: runs the ring array, captures and health-checks samples, hands words out
// Optional RNG_WHITEN_EN: XOR each raw sample with the rotated last delivered word.
module rng_sample_controller
  import rng_ctrl_pkg::*;
#(
  parameter int NUMBITS     = DEF_NUMBITS,
  parameter int RUN_CYCLES  = DEF_RUN_CYCLES,
  parameter int REST_CYCLES = DEF_REST_CYCLES,
  parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    osc_enable,
  input  logic [NUMBITS-1:0]      osc_bits,
  output logic                    busy,
  output logic                    health_fail,
  rng_sample_controller_if.master bus
);
  localparam int CW = $clog2((RUN_CYCLES > REST_CYCLES ? RUN_CYCLES : REST_CYCLES) + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUMBITS-1:0] raw_q, raw_d, prev_q, prev_d, data_q, data_d, sync_q, word;
  logic [RW-1:0]      rep_q, rep_d, rep_next;
  logic               pv_q, pv_d, osc_q, osc_d, valid_q, valid_d, busy_q, busy_d, hf_q, hf_d;
  rng_bit_synchronizer #(.NUMBITS(NUMBITS)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (osc_bits),
    .q   (sync_q)
  );
`ifdef RNG_WHITEN_EN
  logic [NUMBITS-1:0] last_q, last_d;
  always_comb last_d = (state_q == S_OUTPUT && bus.rnd_ready) ? data_q : last_q;
  always_ff @(posedge clk) last_q <= reset ? '0 : last_d;
  assign word = raw_q ^ {last_q[NUMBITS-2:0], last_q[NUMBITS-1]};
`else
  assign word = raw_q;
`endif
  // rep_count saturates; the trip at REP_LIMIT parks the FSM before it could grow further
  assign rep_next = (pv_q && raw_q == prev_q)
                    ? (rep_q == RW'(REP_LIMIT) ? rep_q : rep_q + 1'b1) : RW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    rep_d   = rep_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_RUN : S_IDLE;
        cnt_d   = start ? CW'(RUN_CYCLES - 1) : cnt_q;
      end
      S_RUN: begin
        state_d = (cnt_q == '0) ? S_CAPTURE : S_RUN;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        raw_d   = sync_q;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        rep_d   = rep_next;
        prev_d  = raw_q;
        pv_d    = 1'b1;
        state_d = (rep_next == RW'(REP_LIMIT)) ? S_FAIL : S_OUTPUT;
        data_d  = (rep_next == RW'(REP_LIMIT)) ? data_q : word;
      end
      S_OUTPUT: begin
        state_d = bus.rnd_ready ? S_REST : S_OUTPUT;
        cnt_d   = bus.rnd_ready ? CW'(REST_CYCLES - 1) : cnt_q;
      end
      S_REST: begin
        state_d = (cnt_q != '0) ? S_REST : (start ? S_RUN : S_IDLE);
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : (start ? CW'(RUN_CYCLES - 1) : '0);
      end
      default: state_d = S_FAIL;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state flop
  always_comb begin
    osc_d   = state_d == S_RUN;
    valid_d = state_d == S_OUTPUT;
    busy_d  = state_d != S_IDLE && state_d != S_FAIL;
    hf_d    = hf_q | (state_d == S_FAIL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      raw_q   <= '0;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      rep_q   <= '0;
      data_q  <= '0;
      osc_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      hf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      rep_q   <= rep_d;
      data_q  <= data_d;
      osc_q   <= osc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      hf_q    <= hf_d;
    end
  end
  assign osc_enable    = osc_q;
  assign busy          = busy_q;
  assign health_fail   = hf_q;
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_data  = data_q;
endmodule
